id_stage: RTL and testbench

Decode stage of the five-stage RV32I pipeline, directly downstream of instruction fetch. It takes the fetched instruction, PC and PC+4, and does four things: decodes control signals, generates the sign-extended immediate, reads the 32×32 register file (written back from the W stage), and registers everything into the ID/EX pipeline register. It also exposes the decoded source-register indices so the hazard unit can compute stalls and flushes.

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/regfile.sv | 30 +++
 rtl/id_stage.sv | 165 ++++++++++++++++
 tb/tb_id_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode, ALU and result-select encodings shared by the decode stage.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       illegal;
        logic [1:0] result_src;
        logic [3:0] alu_control;
    } ctrl_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_t t);
        case (t)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // alt is funct7[5]; it means SUB only for register-register ops, SRA for both
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_op);
        case (f3)
            3'b000:  return (alt && is_op) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 2R1W architectural register file with x0 hardwired, write bypass and sync clear.
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage -- control decode, immediate generation, register read,
// and the ID/EX pipeline register.
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus_4_d,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            reg_write_w,
    input  logic [4:0]      rd_w,
    input  logic [XLEN-1:0] result_w,
    output logic [4:0]      rs1_d,
    output logic [4:0]      rs2_d,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus_4_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic [2:0]      funct3_e,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic            branch_e,
    output logic            jump_e,
    output logic            alu_src_a_e,
    output logic            alu_src_b_e,
    output logic            illegal_e,
    output logic [1:0]      result_src_e,
    output logic [3:0]      alu_control_e
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            alt;
    logic [XLEN-1:0] rd1, rd2, imm_ext;
    ctrl_t           ctrl, ctrl_e;
    imm_t            imm_sel;

    assign opcode  = instruction_d[6:0];
    assign funct3  = instruction_d[14:12];
    assign alt     = instruction_d[30];
    assign rs1_d   = instruction_d[19:15];
    assign rs2_d   = instruction_d[24:20];
    assign imm_ext = imm_gen(instruction_d, imm_sel);

    always_comb begin
        ctrl = '0;
        ctrl.result_src = RES_ALU;
        ctrl.alu_control = ALU_ADD;
        imm_sel = IMM_NONE;
        case (opcode)
            OPC_LOAD: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.result_src = RES_MEM;
                imm_sel = IMM_I;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                imm_sel = IMM_S;
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_control = alu_op(funct3, alt, 1'b1);
            end
            OPC_OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_control = alu_op(funct3, alt, 1'b0);
                imm_sel = IMM_I;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_control = ALU_SUB;
                imm_sel = IMM_B;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_sel = IMM_J;
            end
            OPC_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_sel = IMM_I;
            end
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_control = ALU_PASSB;
                imm_sel = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 1'b1;
                imm_sel = IMM_U;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (reg_write_w),
        .wa    (rd_w),
        .wd    (result_w),
        .ra1   (rs1_d),
        .ra2   (rs2_d),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // reset and flush both produce an all-zero, non-illegal bubble
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            rd1_e       <= '0;
            rd2_e       <= '0;
            imm_ext_e   <= '0;
            pc_e        <= '0;
            pc_plus_4_e <= '0;
            rs1_e       <= '0;
            rs2_e       <= '0;
            rd_e        <= '0;
            funct3_e    <= '0;
            ctrl_e      <= '0;
        end else if (!stall_e) begin
            rd1_e       <= rd1;
            rd2_e       <= rd2;
            imm_ext_e   <= imm_ext;
            pc_e        <= pc_d;
            pc_plus_4_e <= pc_plus_4_d;
            rs1_e       <= rs1_d;
            rs2_e       <= rs2_d;
            rd_e        <= instruction_d[11:7];
            funct3_e    <= funct3;
            ctrl_e      <= ctrl;
        end
    end

    assign reg_write_e   = ctrl_e.reg_write;
    assign mem_write_e   = ctrl_e.mem_write;
    assign branch_e      = ctrl_e.branch;
    assign jump_e        = ctrl_e.jump;
    assign alu_src_a_e   = ctrl_e.alu_src_a;
    assign alu_src_b_e   = ctrl_e.alu_src_b;
    assign illegal_e     = ctrl_e.illegal;
    assign result_src_e  = ctrl_e.result_src;
    assign alu_control_e = ctrl_e.alu_control;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage with a register-file reference model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset, stall_e, flush_e, reg_write_w;
    logic [31:0] instruction_d, pc_d, pc_plus_4_d, result_w;
    logic [4:0]  rd_w, rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus_4_e;
    logic [2:0]  funct3_e;
    logic        reg_write_e, mem_write_e, branch_e, jump_e, alu_src_a_e, alu_src_b_e, illegal_e;
    logic [1:0]  result_src_e;
    logic [3:0]  alu_control_e;

    typedef struct {
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  ctl;
        logic [1:0]  rsrc;
        logic [3:0]  alu;
    } exp_t;

    exp_t        q[$];
    exp_t        last, z;
    logic [31:0] mdl [32];
    logic [31:0] pc = 32'h100;
    int          checks = 0, errors = 0;

    id_stage dut (
        .clk(clk), .reset(reset), .instruction_d(instruction_d), .pc_d(pc_d),
        .pc_plus_4_d(pc_plus_4_d), .stall_e(stall_e), .flush_e(flush_e),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
        .pc_e(pc_e), .pc_plus_4_e(pc_plus_4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .funct3_e(funct3_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .branch_e(branch_e), .jump_e(jump_e), .alu_src_a_e(alu_src_a_e),
        .alu_src_b_e(alu_src_b_e), .illegal_e(illegal_e), .result_src_e(result_src_e),
        .alu_control_e(alu_control_e)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // ctl = {reg_write, mem_write, branch, jump, alu_src_a, alu_src_b, illegal}
    function automatic exp_t dec(input logic [31:0] imm, input logic [6:0] ctl,
                                 input logic [1:0] rsrc, input logic [3:0] alu);
        exp_t e;
        e = z;
        e.imm = imm;
        e.ctl = ctl;
        e.rsrc = rsrc;
        e.alu = alu;
        return e;
    endfunction

    function automatic logic [31:0] rdm(input logic [4:0] rs, input logic we,
                                        input logic [4:0] wrd, input logic [31:0] wres);
        if (rs == 5'd0) return 32'd0;
        if (we && wrd == rs) return wres;
        return mdl[rs];
    endfunction

    task automatic step(input logic [31:0] instr, input exp_t d,
                        input logic we = 1'b0, input logic [4:0] wrd = 5'd0,
                        input logic [31:0] wres = 32'd0, input logic stl = 1'b0,
                        input logic fl = 1'b0, input logic rst = 1'b0);
        exp_t e;
        instruction_d = instr;
        pc_d = pc;
        pc_plus_4_d = pc + 32'd4;
        reg_write_w = we;
        rd_w = wrd;
        result_w = wres;
        stall_e = stl;
        flush_e = fl;
        reset = rst;
        #1;
        check("rs1_d", 32'(rs1_d), 32'(instr[19:15]));
        check("rs2_d", 32'(rs2_d), 32'(instr[24:20]));
        if (rst || fl) e = z;
        else if (stl) e = last;
        else begin
            e = d;
            e.pc = pc;
            e.pc4 = pc + 32'd4;
            e.rs1 = instr[19:15];
            e.rs2 = instr[24:20];
            e.rd = instr[11:7];
            e.f3 = instr[14:12];
            e.rd1 = rdm(instr[19:15], we, wrd, wres);
            e.rd2 = rdm(instr[24:20], we, wrd, wres);
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) foreach (mdl[i]) mdl[i] = 32'd0;
        else if (we && wrd != 5'd0) mdl[wrd] = wres;
        pc += 32'd4;
        e = q.pop_front();
        last = e;
        check("rd1_e", rd1_e, e.rd1);
        check("rd2_e", rd2_e, e.rd2);
        check("imm_ext_e", imm_ext_e, e.imm);
        check("pc_e", pc_e, e.pc);
        check("pc_plus_4_e", pc_plus_4_e, e.pc4);
        check("rs1_e", 32'(rs1_e), 32'(e.rs1));
        check("rs2_e", 32'(rs2_e), 32'(e.rs2));
        check("rd_e", 32'(rd_e), 32'(e.rd));
        check("funct3_e", 32'(funct3_e), 32'(e.f3));
        check("ctl_e", 32'({reg_write_e, mem_write_e, branch_e, jump_e, alu_src_a_e,
                            alu_src_b_e, illegal_e}), 32'(e.ctl));
        check("result_src_e", 32'(result_src_e), 32'(e.rsrc));
        check("alu_control_e", 32'(alu_control_e), 32'(e.alu));
    endtask

    initial begin
        logic [4:0] r;
        z = '{default: '0};
        last = z;
        foreach (mdl[i]) mdl[i] = 32'd0;
        step(32'h0, z, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(32'h0, z, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        // populate every register through writeback, then read a pair back
        for (int i = 1; i < 32; i++)
            step(32'h00000033, dec(32'd0, 7'b1000000, 2'd0, 4'd0), 1'b1, 5'(i), i * 32'h01010101);
        step(32'h40208533, dec(32'd0, 7'b1000000, 2'd0, 4'd1));
        // mid-stream reset clears the pipeline register and the register file
        step(32'h0020A423, z, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(32'h0020A423, z, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            r = 5'(i);
            step({7'b0, r, r, 3'b000, 5'b0, 7'b0110011}, dec(32'd0, 7'b1000000, 2'd0, 4'd0));
        end
        step(32'h00128313, dec(32'd1, 7'b1000010, 2'd0, 4'd0), 1'b1, 5'd5, 32'h12345678);
        step(32'h00528533, dec(32'd0, 7'b1000000, 2'd0, 4'd0));
        step(32'h00000033, dec(32'd0, 7'b1000000, 2'd0, 4'd0), 1'b1, 5'd1, 32'h0000_1000);
        step(32'h00000033, dec(32'd0, 7'b1000000, 2'd0, 4'd0), 1'b1, 5'd2, 32'h8000_0003);
        step(32'h0020A423, dec(32'd8, 7'b0100010, 2'd0, 4'd0));
        step(32'hFE000EE3, dec(32'hFFFFFFFC, 7'b0010000, 2'd0, 4'd1));
        step(32'h123453B7, dec(32'h12345000, 7'b1000010, 2'd0, 4'd10));
        step(32'h00001417, dec(32'h00001000, 7'b1000110, 2'd0, 4'd0));
        step(32'h008000EF, dec(32'd8, 7'b1001000, 2'd2, 4'd0));
        step(32'h004100E7, dec(32'd4, 7'b1001010, 2'd2, 4'd0));
        step(32'hFFC1A483, dec(32'hFFFFFFFC, 7'b1000010, 2'd1, 4'd0));
        step(32'h40208533, dec(32'd0, 7'b1000000, 2'd0, 4'd1));
        step(32'h4020D5B3, dec(32'd0, 7'b1000000, 2'd0, 4'd7));
        step(32'h4030D613, dec(32'h00000403, 7'b1000010, 2'd0, 4'd7));
        step(32'hC0008693, dec(32'hFFFFFC00, 7'b1000010, 2'd0, 4'd0));
        step(32'h0020B733, dec(32'd0, 7'b1000000, 2'd0, 4'd9));
        step(32'h0020F7B3, dec(32'd0, 7'b1000000, 2'd0, 4'd2));
        // x0 ignores writes, both bypassed and stored
        step(32'h00000093, dec(32'd0, 7'b1000010, 2'd0, 4'd0), 1'b1, 5'd0, 32'h0000FFFF);
        step(32'h00000093, dec(32'd0, 7'b1000010, 2'd0, 4'd0));
        step(32'h00000000, dec(32'd0, 7'b0000001, 2'd0, 4'd0));
        // hold across three stalled cycles while writeback keeps going
        step(32'h00128313, dec(32'd1, 7'b1000010, 2'd0, 4'd0));
        step(32'h0020A423, z, 1'b1, 5'd5, 32'hAAAA5555, 1'b1);
        step(32'hFE000EE3, z, 1'b0, 5'd0, 32'd0, 1'b1);
        step(32'h123453B7, z, 1'b1, 5'd1, 32'h0BADF00D, 1'b1);
        step(32'h00128313, z, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        step(32'h00128313, dec(32'd1, 7'b1000010, 2'd0, 4'd0));
        step(32'h0020A423, dec(32'd8, 7'b0100010, 2'd0, 4'd0));
        if (q.size() != 0) check("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
